// File: rtl/fwrisc_branch_pkg.sv
// Shared types for the fwrisc branch unit: comparator op encoding, B-type funct3
// codes, FSM states and funct3 decode helpers.
package fwrisc_branch_pkg;

  // Shared with the ALU SLT path through the external comparator.
  typedef enum logic [1:0] {
    COMPARE_EQ  = 2'd0,
    COMPARE_LT  = 2'd1,
    COMPARE_LTU = 2'd2
  } compare_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RSP  = 2'd2
  } branch_state_e;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  function automatic compare_op_e funct3_to_cmp_op(input logic [2:0] funct3);
    compare_op_e op;
    case (funct3)
      FUNCT3_BEQ, FUNCT3_BNE:   op = COMPARE_EQ;
      FUNCT3_BLT, FUNCT3_BGE:   op = COMPARE_LT;
      FUNCT3_BLTU, FUNCT3_BGEU: op = COMPARE_LTU;
      default:                  op = COMPARE_EQ;
    endcase
    return op;
  endfunction

  function automatic logic funct3_inverts(input logic [2:0] funct3);
    logic inv;
    case (funct3)
      FUNCT3_BNE, FUNCT3_BGE, FUNCT3_BGEU: inv = 1'b1;
      default:                             inv = 1'b0;
    endcase
    return inv;
  endfunction

  function automatic logic funct3_is_illegal(input logic [2:0] funct3);
    return (funct3[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/fwrisc_branch_stats.sv
// Response counters for the branch unit: total delivered decisions and taken ones.
// Instantiated only when FWRISC_BRANCH_STATS_EN is defined.
module fwrisc_branch_stats (
  input  logic        clock,
  input  logic        reset,
  input  logic        hs_i,
  input  logic        taken_i,
  output logic [31:0] branches_o,
  output logic [31:0] taken_o
);

  logic [31:0] branches_q, branches_d;
  logic [31:0] taken_q, taken_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    branches_d = branches_q;
    taken_d    = taken_q;
    if (hs_i) begin
      branches_d = branches_q + 32'd1;
      if (taken_i) begin
        taken_d = taken_q + 32'd1;
      end else begin
        taken_d = taken_q;
      end
    end else begin
      branches_d = branches_q;
      taken_d    = taken_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      branches_q <= 32'd0;
      taken_q    <= 32'd0;
    end else begin
      branches_q <= branches_d;
      taken_q    <= taken_d;
    end
  end

  assign branches_o = branches_q;
  assign taken_o    = taken_q;

endmodule

// File: rtl/fwrisc_branch_unit.sv
// Conditional-branch resolution around the shared external EQ/LT/LTU comparator.
// Response counters are built only when FWRISC_BRANCH_STATS_EN is defined.
module fwrisc_branch_unit
  import fwrisc_branch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_imm,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic [31:0] cmp_in_a,
  output logic [31:0] cmp_in_b,
  output logic [1:0]  cmp_op,
  input  logic        cmp_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_taken,
  output logic [31:0] rsp_target,
  output logic        rsp_misalign,
  output logic        rsp_illegal,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_taken
);

  branch_state_e state_q, state_d;
  compare_op_e   cmp_op_q, cmp_op_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   imm_q, imm_d;
  logic [31:0]   rs1_q, rs1_d;
  logic [31:0]   rs2_q, rs2_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_taken_q, rsp_taken_d;
  logic [31:0]   rsp_target_q, rsp_target_d;
  logic          rsp_misalign_q, rsp_misalign_d;
  logic          rsp_illegal_q, rsp_illegal_d;

  logic          req_fire_s;
  logic          rsp_fire_s;
  logic          illegal_s;
  logic          taken_s;
  logic          misalign_s;
  logic [31:0]   taken_tgt_s;
  logic [31:0]   seq_tgt_s;
  logic [31:0]   target_s;

  assign req_fire_s = req_valid && req_ready_q && (state_q == IDLE);
  assign rsp_fire_s = rsp_valid_q && rsp_ready;

  // Decision datapath: comparator result corrected for the inverted funct3 forms.
  always_comb begin
    illegal_s   = funct3_is_illegal(funct3_q);
    taken_s     = (cmp_out ^ funct3_inverts(funct3_q)) & ~illegal_s;
    taken_tgt_s = pc_q + imm_q;
    seq_tgt_s   = pc_q + 32'd4;
    if (taken_s) begin
      target_s = taken_tgt_s;
    end else begin
      target_s = seq_tgt_s;
    end
    misalign_s = taken_s & (target_s[1:0] != 2'b00);
  end

  // Next-state and register-update logic for the IDLE/CMP/RSP handshake FSM.
  always_comb begin
    state_d        = state_q;
    cmp_op_d       = cmp_op_q;
    funct3_d       = funct3_q;
    pc_d           = pc_q;
    imm_d          = imm_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    req_ready_d    = 1'b0;
    rsp_valid_d    = rsp_valid_q;
    rsp_taken_d    = rsp_taken_q;
    rsp_target_d   = rsp_target_q;
    rsp_misalign_d = rsp_misalign_q;
    rsp_illegal_d  = rsp_illegal_q;

    case (state_q)
      IDLE: begin
        if (req_fire_s) begin
          funct3_d = req_funct3;
          pc_d     = req_pc;
          imm_d    = req_imm;
          rs1_d    = req_rs1;
          rs2_d    = req_rs2;
          cmp_op_d = funct3_to_cmp_op(req_funct3);
          state_d  = CMP;
        end else begin
          state_d = IDLE;
        end
      end
      CMP: begin
        rsp_valid_d    = 1'b1;
        rsp_taken_d    = taken_s;
        rsp_target_d   = target_s;
        rsp_misalign_d = misalign_s;
        rsp_illegal_d  = illegal_s;
        state_d        = RSP;
      end
      RSP: begin
        // Response fields return to zero once the decision has been consumed.
        if (rsp_fire_s) begin
          rsp_valid_d    = 1'b0;
          rsp_taken_d    = 1'b0;
          rsp_target_d   = 32'd0;
          rsp_misalign_d = 1'b0;
          rsp_illegal_d  = 1'b0;
          state_d        = IDLE;
        end else begin
          state_d = RSP;
        end
      end
      default: begin
        rsp_valid_d    = 1'b0;
        rsp_taken_d    = 1'b0;
        rsp_target_d   = 32'd0;
        rsp_misalign_d = 1'b0;
        rsp_illegal_d  = 1'b0;
        state_d        = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State and datapath registers; reset drops any pending decision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cmp_op_q       <= COMPARE_EQ;
      funct3_q       <= 3'd0;
      pc_q           <= 32'd0;
      imm_q          <= 32'd0;
      rs1_q          <= 32'd0;
      rs2_q          <= 32'd0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_taken_q    <= 1'b0;
      rsp_target_q   <= 32'd0;
      rsp_misalign_q <= 1'b0;
      rsp_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmp_op_q       <= cmp_op_d;
      funct3_q       <= funct3_d;
      pc_q           <= pc_d;
      imm_q          <= imm_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_taken_q    <= rsp_taken_d;
      rsp_target_q   <= rsp_target_d;
      rsp_misalign_q <= rsp_misalign_d;
      rsp_illegal_q  <= rsp_illegal_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign cmp_in_a     = rs1_q;
  assign cmp_in_b     = rs2_q;
  assign cmp_op       = cmp_op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_taken    = rsp_taken_q;
  assign rsp_target   = rsp_target_q;
  assign rsp_misalign = rsp_misalign_q;
  assign rsp_illegal  = rsp_illegal_q;

`ifdef FWRISC_BRANCH_STATS_EN
  fwrisc_branch_stats u_stats (
    .clock      (clock),
    .reset      (reset),
    .hs_i       (rsp_fire_s),
    .taken_i    (rsp_taken_q),
    .branches_o (stat_branches),
    .taken_o    (stat_taken)
  );
`else
  assign stat_branches = 32'd0;
  assign stat_taken    = 32'd0;
`endif

endmodule

// File: doc/fwrisc_branch_unit.md
# fwrisc_branch_unit

Conditional-branch resolution stage for the fwrisc core, sitting directly downstream of the decoder and wrapped around the shared EQ/LT/LTU comparator. It accepts one branch request at a time and maps funct3 onto a comparator op. It drives the comparator operands from registered state, samples the single-bit result and inverts it where required. It then returns a registered taken/not-taken decision, next-PC target and fault flags to the fetch/PC logic over a valid/ready handshake.

## Interface
- No parameters; datapath fixed at 32 bits.
- clock  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  branch request present
- req_ready  out  1  unit can accept request
- req_funct3  in  3  B-type funct3
- req_pc  in  32  PC of branch instruction
- req_imm  in  32  sign-extended B-immediate
- req_rs1  in  32  rs1 value
- req_rs2  in  32  rs2 value
- cmp_in_a  out  32  comparator operand A (registered rs1)
- cmp_in_b  out  32  comparator operand B (registered rs2)
- cmp_op  out  2  comparator op: 0 EQ, 1 LT, 2 LTU
- cmp_out  in  1  comparator result, combinational from cmp_in_a/cmp_in_b/cmp_op
- rsp_valid  out  1  decision available
- rsp_ready  in  1  consumer accepts decision
- rsp_taken  out  1  branch taken
- rsp_target  out  32  next PC
- rsp_misalign  out  1  taken target not 4-byte aligned
- rsp_illegal  out  1  funct3 010/011
- stat_branches  out  32  responses delivered (see Configuration)
- stat_taken  out  32  taken responses delivered

## Operation
- FSM states IDLE, CMP, RSP; reset → IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, register funct3, pc, imm, rs1, rs2 → CMP.
- CMP: cmp_in_a/b = registered rs1/rs2; cmp_op from funct3 per the mapping below. At end of cycle, register result and targets, then → RSP.
- funct3 mapping: 000 BEQ → EQ; 001 BNE → EQ inverted; 100 BLT → LT; 101 BGE → LT inverted; 110 BLTU → LTU; 111 BGEU → LTU inverted.
- funct3 010/011: rsp_illegal=1, rsp_taken=0, rsp_target=pc+4, cmp_op=EQ (don't-care).
- Targets: taken target = pc+imm; not-taken target = pc+4. Both modulo 2^32, carry discarded, so wrap-around is legal.
- rsp_misalign = rsp_taken && target[1:0]!=0. When set, target is still reported.
- RSP: rsp_valid=1 with fields held stable until rsp_ready. On rsp_valid&&rsp_ready → IDLE.
- No new request is accepted in the handshake cycle.
- Reset (any state, mid-operation): all outputs 0, FSM → IDLE, any pending decision dropped, stat counters cleared.
- req_* are ignored outside IDLE.
- rsp_* are 0 whenever rsp_valid=0.

## Timing
- Request accepted at edge N → rsp_valid high from cycle N+2; latency 2.
- Back-to-back throughput: one branch per 3 cycles when rsp_ready is tied high.
- rsp_ready held low → FSM stays in RSP indefinitely, outputs constant.
- cmp_in_a, cmp_in_b and cmp_op are driven from registers only. The comparator adds one combinational level ending at the result register.
- Reset values: req_ready=0 while reset asserted and 1 after release; every other output 0.

## Configuration
- FWRISC_BRANCH_STATS_EN defined:
  - stat_branches increments on every response handshake.
  - stat_taken increments on handshakes with rsp_taken=1.
  - Both counters are 32-bit, wrap at 2^32, and reset to 0.
- Not defined: stat_branches and stat_taken tied to 0, counter logic absent. Port list is identical in both builds.

## Structure
- fwrisc_branch_pkg holds:
  - compare_op_e (COMPARE_EQ=0, COMPARE_LT=1, COMPARE_LTU=2), moved here for sharing with the comparator;
  - funct3 localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU);
  - branch_state_e FSM enum.
- Sub-module fwrisc_branch_stats contains the two counters. It is instantiated only under FWRISC_BRANCH_STATS_EN.
- The comparator stays external so the ALU SLT path can share it.

## Test plan
- BEQ: rs1=rs2=0x1234, pc=0x100, imm=0x20, rsp_ready=1 → 2 cycles after accept: rsp_valid=1, taken=1, target=0x120, misalign=0, illegal=0.
- BGE signed vs BGEU: rs1=0xFFFFFFFF, rs2=1. BGE → taken=0, target=pc+4; BGEU → taken=1.
- Wrap and alignment checks:
  - pc=0xFFFFFFF0, imm=0x20, BNE with rs1≠rs2 → target=0x00000010.
  - imm=0x22, taken → misalign=1.
- funct3=010 → illegal=1, taken=0, target=pc+4; stat_taken unchanged.
- Backpressure then reset:
  - Hold rsp_ready=0 for 5 cycles → rsp_* stable, req_ready=0.
  - Assert reset in RSP → all outputs 0 and IDLE next cycle, with no response delivered.
- With FWRISC_BRANCH_STATS_EN, 10 branches (4 taken) → stat_branches=10, stat_taken=4. Without the macro, both read 0.
